// File: rtl/uart_rx_frame_ctrl.sv
// Frame controller behind a UART receiver: parses SOF/LEN/payload/checksum frames,
// buffers the payload and releases only checksum-verified payloads on a valid/ready stream.
module uart_rx_frame_ctrl #(
  parameter logic [7:0]  SOF_BYTE      = 8'h7E,
  parameter int unsigned MAX_LEN       = 16,
  parameter int unsigned TIMEOUT_TICKS = 640,
  parameter int unsigned TO_W          = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       s_tick,
  input  logic       rx_done_tick,
  input  logic [7:0] rx_data,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_last,
  input  logic       out_ready,
  output logic       busy,
  output logic       err_len,
  output logic       err_chk,
  output logic       err_timeout,
  output logic       err_overrun,
  output logic [7:0] frame_cnt
);

  localparam int unsigned     AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0]      MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_TICKS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_PAYLOAD,
    S_CHK,
    S_DRAIN
  } state_t;

  state_t          state, state_n;
  logic [7:0]      len, len_n;
  logic [7:0]      idx, idx_n;
  logic [7:0]      chk, chk_n;
  logic [TO_W-1:0] to_cnt, to_cnt_n;
  logic [7:0]      frame_cnt_n;
  logic            out_valid_n, out_last_n;
  logic [7:0]      out_data_n;
  logic            busy_n;
  logic            err_len_n, err_chk_n, err_timeout_n, err_overrun_n;
  logic            wr_en;
  logic            timed;
  logic            timeout_hit;

  logic [7:0] mem [MAX_LEN];

  // Payload buffer; contents need no reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[AW'(idx)] <= rx_data;
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_n;
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      len         <= '0;
      idx         <= '0;
      chk         <= '0;
      to_cnt      <= '0;
      frame_cnt   <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_last    <= 1'b0;
      busy        <= 1'b0;
      err_len     <= 1'b0;
      err_chk     <= 1'b0;
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      len         <= len_n;
      idx         <= idx_n;
      chk         <= chk_n;
      to_cnt      <= to_cnt_n;
      frame_cnt   <= frame_cnt_n;
      out_valid   <= out_valid_n;
      out_data    <= out_data_n;
      out_last    <= out_last_n;
      busy        <= busy_n;
      err_len     <= err_len_n;
      err_chk     <= err_chk_n;
      err_timeout <= err_timeout_n;
      err_overrun <= err_overrun_n;
    end
  end

  // Inter-byte timeout runs only while a frame is being received; a byte beats the terminal tick.
  assign timed       = (state == S_LEN) || (state == S_PAYLOAD) || (state == S_CHK);
  assign timeout_hit = timed && !rx_done_tick && s_tick && (to_cnt == TO_LAST);

  // Next-state and next-output logic.
  always_comb begin
    state_n       = state;
    len_n         = len;
    idx_n         = idx;
    chk_n         = chk;
    to_cnt_n      = to_cnt;
    frame_cnt_n   = frame_cnt;
    out_valid_n   = out_valid;
    out_data_n    = out_data;
    out_last_n    = out_last;
    err_len_n     = 1'b0;
    err_chk_n     = 1'b0;
    err_timeout_n = 1'b0;
    err_overrun_n = 1'b0;
    wr_en         = 1'b0;

    if (timed) begin
      if (rx_done_tick) to_cnt_n = '0;
      else if (s_tick)  to_cnt_n = to_cnt + TO_W'(1);
    end

    case (state)
      S_IDLE: begin
        to_cnt_n = '0;
        if (rx_done_tick && (rx_data == SOF_BYTE)) state_n = S_LEN;
      end
      S_LEN: begin
        if (rx_done_tick) begin
          if ((rx_data == 8'd0) || (rx_data > MAX_LEN_B)) begin
            err_len_n = 1'b1;
            state_n   = S_IDLE;
          end else begin
            len_n   = rx_data;
            chk_n   = rx_data;
            idx_n   = '0;
            state_n = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        if (rx_done_tick) begin
          wr_en = 1'b1;
          chk_n = chk ^ rx_data;
          idx_n = idx + 8'd1;
          if ((idx + 8'd1) == len) state_n = S_CHK;
        end
      end
      S_CHK: begin
        if (rx_done_tick) begin
          if (rx_data == chk) begin
            frame_cnt_n = frame_cnt + 8'd1;
            idx_n       = '0;
            out_valid_n = 1'b1;
            out_data_n  = mem[AW'(0)];
            out_last_n  = (len == 8'd1);
            state_n     = S_DRAIN;
          end else begin
            err_chk_n = 1'b1;
            state_n   = S_IDLE;
          end
        end
      end
      S_DRAIN: begin
        to_cnt_n = '0;
        if (rx_done_tick) err_overrun_n = 1'b1;
        if (out_valid && out_ready) begin
          if (out_last) begin
            out_valid_n = 1'b0;
            out_last_n  = 1'b0;
            out_data_n  = '0;
            idx_n       = '0;
            state_n     = S_IDLE;
          end else begin
            idx_n      = idx + 8'd1;
            out_data_n = mem[AW'(idx + 8'd1)];
            out_last_n = ((idx + 8'd2) == len);
          end
        end
      end
      default: state_n = S_IDLE;
    endcase

    if (timeout_hit) begin
      err_timeout_n = 1'b1;
      to_cnt_n      = '0;
      state_n       = S_IDLE;
    end

    busy_n = (state_n != S_IDLE);
  end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Bench for uart_rx_frame_ctrl: frame-level reference model with per-cycle compare,
// directed scenarios with literal expectations, then randomized frame traffic.
module tb_uart_rx_frame_ctrl;

  localparam int TIMEOUT = 640;
  localparam int MAXL    = 16;

  logic       clk;
  logic       reset_n;
  logic       s_tick;
  logic       rx_done_tick;
  logic [7:0] rx_data;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_last;
  logic       out_ready;
  logic       busy;
  logic       err_len, err_chk, err_timeout, err_overrun;
  logic [7:0] frame_cnt;

  logic [7:0] sof;

  int total = 0;
  int bad   = 0;

  uart_rx_frame_ctrl #(
    .SOF_BYTE(8'h7E), .MAX_LEN(MAXL), .TIMEOUT_TICKS(TIMEOUT), .TO_W(16)
  ) dut (
    .clk(clk), .reset_n(reset_n), .s_tick(s_tick), .rx_done_tick(rx_done_tick),
    .rx_data(rx_data), .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready), .busy(busy), .err_len(err_len), .err_chk(err_chk),
    .err_timeout(err_timeout), .err_overrun(err_overrun), .frame_cnt(frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h at t=%0t", nm, act, exp, $time);
    end
  endfunction

  // Reference model: bytes collected since SOF, bytes still to be drained.
  bit         m_in_frame;
  logic [7:0] m_got[$];
  logic [7:0] m_drain[$];
  int         m_idle;
  logic [7:0] m_cnt;
  bit         m_elen, m_echk, m_eto, m_eov;
  int         m_n, m_l;
  logic [7:0] m_x;

  task automatic model_clear();
    m_in_frame = 0; m_got.delete(); m_drain.delete(); m_idle = 0; m_cnt = 8'd0;
    m_elen = 0; m_echk = 0; m_eto = 0; m_eov = 0;
  endtask

  task automatic model_step();
    m_elen = 0; m_echk = 0; m_eto = 0; m_eov = 0;
    if (m_drain.size() != 0) begin
      if (rx_done_tick) m_eov = 1;
      if (out_ready) void'(m_drain.pop_front());
    end else if (m_in_frame) begin
      if (rx_done_tick) begin
        m_got.push_back(rx_data);
        m_idle = 0;
        m_n = m_got.size();
        m_l = int'(m_got[0]);
        if (m_n == 1) begin
          if (m_l == 0 || m_l > MAXL) begin m_elen = 1; m_in_frame = 0; end
        end else if (m_n == m_l + 2) begin
          m_x = 8'd0;
          for (int i = 0; i <= m_l; i++) m_x = m_x ^ m_got[i];
          if (m_x == m_got[m_l+1]) begin
            for (int i = 1; i <= m_l; i++) m_drain.push_back(m_got[i]);
            m_cnt = m_cnt + 8'd1;
          end else m_echk = 1;
          m_in_frame = 0;
        end
      end else if (s_tick) begin
        m_idle++;
        if (m_idle == TIMEOUT) begin m_eto = 1; m_in_frame = 0; end
      end
    end else if (rx_done_tick && rx_data == sof) begin
      m_in_frame = 1; m_got.delete(); m_idle = 0;
    end
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) model_clear();
      else model_step();
    end
  end

  // Observed handshakes and error pulses.
  logic [7:0] act_b[$];
  bit         act_l[$];
  int n_len = 0, n_chk = 0, n_to = 0, n_ov = 0;

  // Per-cycle compare against the model.
  initial begin
    forever begin
      @(negedge clk);
      check("busy", busy, (m_in_frame || m_drain.size() != 0) ? 1 : 0);
      check("out_valid", out_valid, (m_drain.size() != 0) ? 1 : 0);
      check("err_len", err_len, m_elen);
      check("err_chk", err_chk, m_echk);
      check("err_timeout", err_timeout, m_eto);
      check("err_overrun", err_overrun, m_eov);
      check("frame_cnt", frame_cnt, m_cnt);
      if (m_drain.size() != 0) begin
        check("out_data", out_data, m_drain[0]);
        check("out_last", out_last, (m_drain.size() == 1) ? 1 : 0);
      end else if (!reset_n) begin
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
      end
      if (reset_n) begin
        if (out_valid && out_ready) begin act_b.push_back(out_data); act_l.push_back(out_last); end
        n_len += int'(err_len); n_chk += int'(err_chk);
        n_to  += int'(err_timeout); n_ov += int'(err_overrun);
      end
    end
  end

  bit ready_rand = 0;
  initial begin
    forever begin
      @(posedge clk); #1;
      if (ready_rand) out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input bit trand);
    for (int i = 0; i < gap; i++) begin
      s_tick = trand ? 1'($urandom_range(0, 1)) : 1'b0;
      cyc();
    end
    rx_done_tick = 1'b1; rx_data = b;
    s_tick = trand ? 1'($urandom_range(0, 1)) : 1'b0;
    cyc();
    rx_done_tick = 1'b0; s_tick = 1'b0;
  endtask

  task automatic send_frame(input int len, input bit corrupt, input int gmax);
    logic [7:0] b, c;
    c = 8'(len);
    send_byte(sof, $urandom_range(0, gmax), gmax > 0);
    send_byte(8'(len), $urandom_range(0, gmax), gmax > 0);
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom);
      c = c ^ b;
      send_byte(b, $urandom_range(0, gmax), gmax > 0);
    end
    if (corrupt) c = c ^ 8'h5A;
    send_byte(c, $urandom_range(0, gmax), gmax > 0);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 3000 && busy; i++) cyc();
    check("wait_idle", busy, 0);
  endtask

  int snap;
  int kind;
  logic [7:0] nb;

  initial begin
    sof = 8'h7E;
    reset_n = 1'b0; s_tick = 1'b0; rx_done_tick = 1'b0; rx_data = 8'h00; out_ready = 1'b1;
    repeat (3) cyc();
    check("rst_busy", busy, 0);
    check("rst_valid", out_valid, 0);
    check("rst_cnt", frame_cnt, 0);
    reset_n = 1'b1;
    cyc();

    // Good frame 7E 03 11 22 33 03
    act_b.delete(); act_l.delete();
    send_byte(8'h7E, 0, 0); send_byte(8'h03, 0, 0); send_byte(8'h11, 0, 0);
    send_byte(8'h22, 0, 0); send_byte(8'h33, 0, 0); send_byte(8'h03, 0, 0);
    check("good_first_valid", out_valid, 1);
    check("good_first_data", out_data, 8'h11);
    wait_idle();
    check("good_count", act_b.size(), 3);
    if (act_b.size() == 3) begin
      check("good_b0", act_b[0], 8'h11); check("good_b1", act_b[1], 8'h22);
      check("good_b2", act_b[2], 8'h33);
      check("good_last", {act_l[0], act_l[1], act_l[2]}, 3'b001);
    end
    check("good_frame_cnt", frame_cnt, 1);
    check("good_no_err", n_len + n_chk + n_to + n_ov, 0);

    // Backpressure 1,0,0,1,1
    act_b.delete();
    send_byte(8'h7E, 0, 0); send_byte(8'h03, 0, 0); send_byte(8'h11, 0, 0);
    send_byte(8'h22, 0, 0); send_byte(8'h33, 0, 0);
    out_ready = 1'b1; send_byte(8'h03, 0, 0);
    cyc();
    out_ready = 1'b0; cyc(); cyc();
    check("bp_hold_data", out_data, 8'h22);
    out_ready = 1'b1; cyc(); cyc();
    check("bp_busy_after", busy, 0);
    check("bp_handshakes", act_b.size(), 3);
    check("bp_frame_cnt", frame_cnt, 2);

    // Length errors
    snap = n_len;
    send_byte(8'h7E, 0, 0); send_byte(8'h00, 0, 0);
    check("len0_pulse", err_len, 1);
    check("len0_idle", busy, 0);
    send_byte(8'h7E, 0, 0); send_byte(8'h11, 0, 0);
    check("len17_pulses", n_len - snap + int'(err_len), 2);

    // Checksum error
    act_b.delete(); snap = n_chk;
    send_byte(8'h7E, 0, 0); send_byte(8'h01, 0, 0); send_byte(8'hAA, 0, 0); send_byte(8'h00, 0, 0);
    check("chk_pulse", err_chk, 1);
    cyc(); cyc();
    check("chk_no_valid", act_b.size(), 0);
    check("chk_cnt_kept", frame_cnt, 2);

    // Timeout after 640 ticks
    snap = n_to;
    send_byte(8'h7E, 0, 0); send_byte(8'h02, 0, 0); send_byte(8'h55, 0, 0);
    s_tick = 1'b1;
    repeat (639) cyc();
    check("to_not_yet", err_timeout, 0);
    check("to_busy", busy, 1);
    cyc();
    s_tick = 1'b0;
    check("to_fire", err_timeout, 1);
    check("to_idle", busy, 0);
    send_byte(8'h7E, 0, 0); send_byte(8'h02, 0, 0); send_byte(8'h01, 0, 0);
    send_byte(8'h02, 0, 0); send_byte(8'h01, 0, 0);
    wait_idle();
    check("to_recover_cnt", frame_cnt, 3);

    // Byte coincident with 640th tick wins
    act_b.delete(); snap = n_to;
    send_byte(8'h7E, 0, 0); send_byte(8'h02, 0, 0); send_byte(8'h55, 0, 0);
    s_tick = 1'b1;
    repeat (639) cyc();
    rx_done_tick = 1'b1; rx_data = 8'h66;
    cyc();
    rx_done_tick = 1'b0; s_tick = 1'b0;
    check("coinc_no_to", n_to - snap + int'(err_timeout), 0);
    check("coinc_busy", busy, 1);
    send_byte(8'h31, 0, 0);
    wait_idle();
    check("coinc_cnt", frame_cnt, 4);
    check("coinc_bytes", act_b.size(), 2);
    if (act_b.size() == 2) check("coinc_b1", act_b[1], 8'h66);

    // Overrun while draining stalled
    act_b.delete(); snap = n_ov;
    out_ready = 1'b0;
    send_byte(8'h7E, 0, 0); send_byte(8'h02, 0, 0); send_byte(8'hA1, 0, 0);
    send_byte(8'hB2, 0, 0); send_byte(8'h02 ^ 8'hA1 ^ 8'hB2, 0, 0);
    send_byte(8'h7E, 1, 0);
    check("ovr_pulse", err_overrun, 1);
    out_ready = 1'b1;
    wait_idle();
    check("ovr_bytes", act_b.size(), 2);
    if (act_b.size() == 2) begin
      check("ovr_b0", act_b[0], 8'hA1); check("ovr_b1", act_b[1], 8'hB2);
    end
    check("ovr_cnt", frame_cnt, 5);

    // Reset mid-payload
    snap = n_len + n_chk + n_to + n_ov;
    send_byte(8'h7E, 0, 0); send_byte(8'h04, 0, 0); send_byte(8'h01, 0, 0);
    reset_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_cnt", frame_cnt, 0);
    check("mid_rst_errs", {err_len, err_chk, err_timeout, err_overrun, out_valid}, 0);
    cyc(); cyc();
    reset_n = 1'b1;
    cyc();
    send_frame(4, 0, 0);
    wait_idle();
    check("mid_rst_no_err", n_len + n_chk + n_to + n_ov, snap);
    check("mid_rst_next", frame_cnt, 1);

    // Noise in IDLE
    for (int i = 0; i < 20; i++) begin
      nb = 8'($urandom);
      if (nb == 8'h7E) nb = 8'h7F;
      send_byte(nb, $urandom_range(0, 2), 1);
      check("noise_busy", busy, 0);
    end

    // Wrap: 256 good frames from reset
    reset_n = 1'b0; cyc(); reset_n = 1'b1; cyc();
    ready_rand = 1;
    snap = n_len + n_chk + n_to + n_ov;
    for (int f = 0; f < 256; f++) begin
      send_frame($urandom_range(1, MAXL), 0, 2);
      wait_idle();
    end
    check("wrap_cnt", frame_cnt, 0);
    check("wrap_no_err", n_len + n_chk + n_to + n_ov, snap);

    // Random mix checked by the model
    for (int r = 0; r < 250; r++) begin
      kind = $urandom_range(0, 9);
      case (kind)
        0, 1, 2, 3: send_frame($urandom_range(1, MAXL), 0, 3);
        4:          send_frame($urandom_range(1, MAXL), 1, 3);
        5: begin
          send_byte(sof, $urandom_range(0, 3), 1);
          send_byte(($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(MAXL + 1, 255)), 1, 1);
        end
        6: begin
          nb = 8'($urandom);
          if (nb == 8'h7E) nb = 8'h00;
          send_byte(nb, $urandom_range(0, 3), 1);
        end
        default: begin
          send_frame($urandom_range(1, MAXL), 0, 1);
          wait_idle();
        end
      endcase
    end
    ready_rand = 0;
    out_ready = 1'b1;
    cyc();
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000000;
    $display("FAIL global_timeout: actual=running required=done");
    $fatal(1, "bench time limit");
  end

endmodule
